// File: rtl/defect_pkg.sv
`default_nettype none
// ============================================================================
// Module  : defect_pkg
// Brief   : Shared FSM encodings, pixel constants and width helpers for the
//           defect analysis streaming stages.
// Revision: 1.0 - initial release
// ============================================================================
package defect_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCUM  = 2'd1;
    localparam state_t REPORT = 2'd2;

    // Binary image encoding produced by the thresholding stage
    localparam logic [7:0] PIX_SET = 8'hFF;
    localparam logic [7:0] PIX_CLR = 8'h00;

    function automatic int calc_pos_w(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    function automatic int calc_cnt_w(input int width, input int height);
        return $clog2(width * height + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/defect_analyzer_raster_counter.sv
`default_nettype none
// ============================================================================
// Module  : raster_counter
// Brief   : Raster x/y position tracker with enable, wrap and end-of-frame flag.
// Revision: 1.0 - initial release
// ============================================================================
module raster_counter #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int X_W    = 6,
    parameter int Y_W    = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           eof
);

    localparam logic [X_W-1:0] C_LAST_X = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] C_LAST_Y = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (r_x == C_LAST_X) begin
                r_x <= '0;
                r_y <= (r_y == C_LAST_Y) ? '0 : r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    assign x   = r_x;
    assign y   = r_y;
    assign eof = (r_x == C_LAST_X) && (r_y == C_LAST_Y);

endmodule
`default_nettype wire

// File: rtl/defect_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : defect_analyzer
// Brief   : Per-frame set-pixel count, bounding box and min-area defect flag
//           over a binary raster stream, reported on a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module defect_analyzer
    import defect_pkg::*;
#(
    parameter  int IMG_WIDTH  = 64,
    parameter  int IMG_HEIGHT = 64,
    parameter  int DATA_WIDTH = 8,
    localparam int X_W        = calc_pos_w(IMG_WIDTH),
    localparam int Y_W        = calc_pos_w(IMG_HEIGHT),
    localparam int CNT_W      = calc_cnt_w(IMG_WIDTH, IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_pixel,
    input  logic                  s_last,
    input  logic [CNT_W-1:0]      min_area,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [CNT_W-1:0]      r_count,
    output logic [X_W-1:0]        r_xmin,
    output logic [X_W-1:0]        r_xmax,
    output logic [Y_W-1:0]        r_ymin,
    output logic [Y_W-1:0]        r_ymax,
    output logic                  r_bbox_valid,
    output logic                  r_defect,
    output logic                  r_frame_err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_acc_count;
    logic [CNT_W-1:0] r_min_area;
    logic [X_W-1:0]   r_acc_xmin, r_acc_xmax;
    logic [Y_W-1:0]   r_acc_ymin, r_acc_ymax;
    logic             r_acc_err;

    logic             w_accept, w_first, w_set, w_eof;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic [CNT_W-1:0] w_base_count, w_thresh, w_nxt_count;
    logic [X_W-1:0]   w_nxt_xmin, w_nxt_xmax;
    logic [Y_W-1:0]   w_nxt_ymin, w_nxt_ymax;
    logic             w_nxt_err, w_nxt_defect;

    assign s_ready  = (r_state == IDLE) || (r_state == ACCUM);
    assign w_accept = s_valid && s_ready;
    assign w_first  = (r_state == IDLE);
    assign w_set    = (s_pixel != '0);

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_raster (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_accept),
        .x     (w_x),
        .y     (w_y),
        .eof   (w_eof)
    );

    // The first pixel of a frame starts from a clean slate rather than the
    // previous frame's accumulators, so the frame needs no separate clear cycle.
    always_comb begin
        w_base_count = w_first ? '0 : r_acc_count;
        w_thresh     = w_first ? min_area : r_min_area;
        w_nxt_count  = w_base_count;
        w_nxt_xmin   = w_first ? '0 : r_acc_xmin;
        w_nxt_xmax   = w_first ? '0 : r_acc_xmax;
        w_nxt_ymin   = w_first ? '0 : r_acc_ymin;
        w_nxt_ymax   = w_first ? '0 : r_acc_ymax;
        if (w_set) begin
            w_nxt_count = w_base_count + CNT_W'(1);
            if (w_base_count == '0) begin
                w_nxt_xmin = w_x;
                w_nxt_xmax = w_x;
                w_nxt_ymin = w_y;
                w_nxt_ymax = w_y;
            end else begin
                if (w_x < w_nxt_xmin) w_nxt_xmin = w_x;
                if (w_x > w_nxt_xmax) w_nxt_xmax = w_x;
                if (w_y < w_nxt_ymin) w_nxt_ymin = w_y;
                if (w_y > w_nxt_ymax) w_nxt_ymax = w_y;
            end
        end
        w_nxt_err    = ((w_first ? 1'b0 : r_acc_err)) | (s_last != w_eof);
        w_nxt_defect = (w_nxt_count != '0) && (w_nxt_count >= w_thresh);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_acc_count  <= '0;
            r_min_area   <= '0;
            r_acc_xmin   <= '0;
            r_acc_xmax   <= '0;
            r_acc_ymin   <= '0;
            r_acc_ymax   <= '0;
            r_acc_err    <= 1'b0;
            r_valid      <= 1'b0;
            r_count      <= '0;
            r_xmin       <= '0;
            r_xmax       <= '0;
            r_ymin       <= '0;
            r_ymax       <= '0;
            r_bbox_valid <= 1'b0;
            r_defect     <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc_count <= w_nxt_count;
                        r_acc_xmin  <= w_nxt_xmin;
                        r_acc_xmax  <= w_nxt_xmax;
                        r_acc_ymin  <= w_nxt_ymin;
                        r_acc_ymax  <= w_nxt_ymax;
                        r_acc_err   <= w_nxt_err;
                        if (w_first) r_min_area <= min_area;
                        if (w_eof) begin
                            r_state      <= REPORT;
                            r_valid      <= 1'b1;
                            r_count      <= w_nxt_count;
                            r_xmin       <= w_nxt_xmin;
                            r_xmax       <= w_nxt_xmax;
                            r_ymin       <= w_nxt_ymin;
                            r_ymax       <= w_nxt_ymax;
                            r_bbox_valid <= (w_nxt_count != '0);
                            r_defect     <= w_nxt_defect;
                            r_frame_err  <= w_nxt_err;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                REPORT: begin
                    if (r_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_defect_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : tb_defect_analyzer
// Brief   : Directed self-checking bench for defect_analyzer (64x64 frames).
// Revision: 1.0 - initial release
// ============================================================================
module tb_defect_analyzer;
    import defect_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_pixel;
    logic        s_last;
    logic [12:0] min_area;
    logic        r_valid;
    logic        r_ready;
    logic [12:0] r_count;
    logic [5:0]  r_xmin, r_xmax, r_ymin, r_ymax;
    logic        r_bbox_valid, r_defect, r_frame_err;

    int n_checks = 0;
    int n_errors = 0;
    bit img [0:4095];

    defect_analyzer #(
        .IMG_WIDTH  (64),
        .IMG_HEIGHT (64),
        .DATA_WIDTH (8)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_pixel      (s_pixel),
        .s_last       (s_last),
        .min_area     (min_area),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_count      (r_count),
        .r_xmin       (r_xmin),
        .r_xmax       (r_xmax),
        .r_ymin       (r_ymin),
        .r_ymax       (r_ymax),
        .r_bbox_valid (r_bbox_valid),
        .r_defect     (r_defect),
        .r_frame_err  (r_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_img(input bit val);
        for (int i = 0; i < 4096; i++) img[i] = val;
    endtask

    task automatic set_px(input int x, input int y);
        img[y * 64 + x] = 1'b1;
    endtask

    // Streams n pixels from img; min_area is scrambled after the first pixel
    // so only the value sampled at frame start may influence the verdict.
    task automatic send_frame(input string tag, input int n, input logic [12:0] ma,
                              input bit gaps, input int early_last, input bit final_last);
        int p     = 0;
        int guard = 0;
        int early_valid = 0;
        while (p < n) begin
            @(negedge clk);
            if (r_valid) early_valid++;
            s_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            min_area = (p == 0) ? ma : (13'h1ABC ^ 13'(p));
            s_pixel  = img[p] ? PIX_SET : PIX_CLR;
            s_last   = ((p == 4095) && final_last) || (p == early_last);
            if (s_valid && s_ready) p++;
            guard++;
            if (guard > 20000) begin
                check({tag, ".timeout"}, 32'(p), 32'(n));
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_pixel = PIX_CLR;
        check({tag, ".no_early_valid"}, 32'(early_valid), 0);
    endtask

    // Called on the first falling edge after the final pixel was accepted.
    task automatic check_result(input string tag, input int cnt, input int xmin, input int xmax,
                                input int ymin, input int ymax, input int bbv, input int def,
                                input int err, input int hold);
        int bad = 0;
        check({tag, ".valid"},  32'(r_valid), 1);
        check({tag, ".count"},  32'(r_count), 32'(cnt));
        check({tag, ".xmin"},   32'(r_xmin), 32'(xmin));
        check({tag, ".xmax"},   32'(r_xmax), 32'(xmax));
        check({tag, ".ymin"},   32'(r_ymin), 32'(ymin));
        check({tag, ".ymax"},   32'(r_ymax), 32'(ymax));
        check({tag, ".bbox_v"}, 32'(r_bbox_valid), 32'(bbv));
        check({tag, ".defect"}, 32'(r_defect), 32'(def));
        check({tag, ".ferr"},   32'(r_frame_err), 32'(err));
        check({tag, ".s_ready_report"}, 32'(s_ready), 0);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (!r_valid || s_ready || (r_count != 13'(cnt))) bad++;
            end
            check({tag, ".hold_stable"}, 32'(bad), 0);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(r_valid), 0);
        check({tag, ".s_ready_idle"}, 32'(s_ready), 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_pixel  = PIX_CLR;
        s_last   = 1'b0;
        min_area = '0;
        r_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(r_valid), 0);
        check("rst.count", 32'(r_count), 0);
        check("rst.defect", 32'(r_defect), 0);
        check("rst.ferr", 32'(r_frame_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.s_ready", 32'(s_ready), 1);

        fill_img(1'b0);
        send_frame("empty", 4096, 13'd0, 1'b0, -1, 1'b1);
        check_result("empty", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        set_px(10, 20);
        send_frame("single", 4096, 13'd1, 1'b0, -1, 1'b1);
        check_result("single", 1, 10, 10, 20, 20, 1, 1, 0, 0);

        fill_img(1'b0);
        for (int y = 40; y <= 42; y++)
            for (int x = 5; x <= 7; x++) set_px(x, y);
        send_frame("blk_ma10", 4096, 13'd10, 1'b0, -1, 1'b1);
        check_result("blk_ma10", 9, 5, 7, 40, 42, 1, 0, 0, 0);
        send_frame("blk_ma9", 4096, 13'd9, 1'b0, -1, 1'b1);
        check_result("blk_ma9", 9, 5, 7, 40, 42, 1, 1, 0, 0);

        fill_img(1'b0);
        set_px(63, 63);
        send_frame("early_last", 4096, 13'd2, 1'b0, 100, 1'b1);
        check_result("early_last", 1, 63, 63, 63, 63, 1, 0, 1, 0);

        fill_img(1'b0);
        send_frame("no_last", 4096, 13'd0, 1'b0, -1, 1'b0);
        check_result("no_last", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        fill_img(1'b1);
        send_frame("full", 4096, 13'd100, 1'b1, -1, 1'b1);
        check_result("full", 4096, 0, 63, 0, 63, 1, 1, 0, 50);

        send_frame("partial", 2000, 13'd1, 1'b0, -1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.valid", 32'(r_valid), 0);
        check("midrst.count", 32'(r_count), 0);
        check("midrst.xmax", 32'(r_xmax), 0);
        check("midrst.bbox_v", 32'(r_bbox_valid), 0);
        check("midrst.defect", 32'(r_defect), 0);
        rst_n = 1'b1;

        fill_img(1'b0);
        set_px(0, 0);
        send_frame("after_rst", 4096, 13'd1, 1'b0, -1, 1'b1);
        check_result("after_rst", 1, 0, 0, 0, 0, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
